tank_plant_model: RTL
=====================

// Module: tank_plant_model
// PURPOSE
//   Closed-loop plant model of the water tank; counterpart of the pump controller.
//   Consumes pump commands b1/b2, integrates tank level against a configurable drain,
//   drives low/high level sensors back to the controller.
//   Used in system sims and FPGA demo builds in place of the physical tank.
// PARAMETERS
//   LEVEL_W     8    level register width
//   CAPACITY    200  maximum level, must be <= 2**LEVEL_W-1
//   LOW_MARK    60   i_sens asserts when level >= LOW_MARK
//   HIGH_MARK   160  s_sens asserts when level >= HIGH_MARK; LOW_MARK < HIGH_MARK <= CAPACITY
//   FILL_RATE   2    units added per tick per running pump
//   TICK_DIV    4    clk cycles per plant tick, >= 1
//   INIT_LEVEL  0    level loaded on reset
// PORTS
//   clk          in   1        clock
//   reset        in   1        synchronous, active-high reset
//   b1           in   1        pump 1 running
//   b2           in   1        pump 2 running
//   drain_en     in   1        consumer drawing water
//   drain_rate   in   4        units removed per tick when drain_en=1
//   clear_flags  in   1        clears sticky overflow/underflow
//   i_sens       out  1        lower sensor (registered)
//   s_sens       out  1        upper sensor (registered)
//   level        out  LEVEL_W  current level
//   region       out  2        {s_sens,i_sens}: 00 EMPTY, 01 HALF, 11 FULL, 10 INVALID
//   overflow     out  1        sticky: a fill was clipped at CAPACITY
//   underflow    out  1        sticky: a drain was clipped at 0
//   run1_cnt     out  16       ticks with b1=1, saturates at 16'hFFFF
//   run2_cnt     out  16       ticks with b2=1, saturates at 16'hFFFF
// BEHAVIOUR
//   - Reset values:
//     - level=INIT_LEVEL; overflow=underflow=0; run counters=0; prescaler=0.
//     - i_sens/s_sens/region are the sensor functions of INIT_LEVEL.
//     - Reset mid-run aborts the pending tick.
//   - Prescaler counts 0..TICK_DIV-1. tick=1 on the cycle count==TICK_DIV-1, then wraps.
//     TICK_DIV=1 gives a tick every cycle.
//   - Inputs b1, b2, drain_en and drain_rate are sampled only on the tick cycle.
//   - Level update on tick:
//     - nxt = level + (b1+b2)*FILL_RATE - (drain_en ? drain_rate : 0).
//     - Computed signed, LEVEL_W+3 bits wide.
//     - nxt > CAPACITY: level=CAPACITY, overflow<=1.
//     - nxt < 0: level=0, underflow<=1.
//     - Otherwise level=nxt.
//     - Fill and drain are netted before clipping. A fill that cancels the drain
//       sets neither flag.
//   - Sensors are registered from the updated level. They change 1 clk after level
//     changes, i.e. 1 cycle after the tick edge.
//   - Region FSM EMPTY/HALF/FULL follows the sensors, with no hysteresis.
//     Multi-region jumps in one tick are legal (large FILL_RATE).
//   - clear_flags clears overflow/underflow on any cycle.
//     If a tick sets a flag in the same cycle as clear_flags, the set wins.
//   - Run counters increment on tick while the matching pump is on.
//     Both pumps on increments both.
// CONFIGURATION
//   SENSOR_FAULT_EN defined:
//     - Adds inputs fault_s_stuck (1) and fault_i_stuck (1).
//     - fault_s_stuck forces s_sens=1; fault_i_stuck forces i_sens=0.
//     - Applied at the output register; region reports 10 (INVALID) when both are forced.
//     - Level integration is unaffected.
//   SENSOR_FAULT_EN undefined:
//     - Ports absent.
//     - Sensors are purely level-derived; region 10 is unreachable.
// STRUCTURE
//   Shared package tank_pkg:
//     - Region encodings EMPTY=2'b00, HALF=2'b01, FULL=2'b11, INVALID=2'b10.
//       These match the controller's state codes and are reused by both blocks.
//     - Sensor-pair typedef.
//   Sub-module sat_counter16 (sat_counter16): inc/clr enables, instantiated twice
//   for run1_cnt and run2_cnt.
//   Prescaler, level datapath and flags stay in this module.
// TESTING
//   1. Fill from empty:
//      - Stimulus: reset with INIT_LEVEL=0, then b1=b2=1, drain off.
//      - Level steps 0,4,8,... every 4 clk.
//      - i_sens rises 1 clk after level reaches 60; s_sens rises 1 clk after level reaches 160.
//      - level holds at 200; overflow=1.
//   2. Drain:
//      - Stimulus: level=10, pumps off, drain_en=1, drain_rate=4.
//      - Level goes 10, 6, 2, then 0; underflow=1 on the clipping tick. region=00.
//   3. Net zero:
//      - Stimulus: b1=1, drain_rate=2, level=100.
//      - level stays 100 indefinitely; no flag set. run1_cnt increments once per 4 clk.
//   4. Flag clear race:
//      - Stimulus: clear_flags=1 on the same cycle as a clipping tick.
//      - overflow stays 1. A clear on the next cycle drives overflow to 0.
//   5. Reset mid-tick:
//      - Stimulus: assert reset at prescaler=2 while filling.
//      - Next cycle: level=INIT_LEVEL, counters=0, prescaler=0.
//      - First tick occurs 4 clk after reset deasserts.
//   6. Faults (SENSOR_FAULT_EN):
//      - Stimulus: level=30, fault_s_stuck=1.
//      - Output {s,i}=10; level still integrates normally.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared definitions for the tank plant model and the pump controller.
// The region codes are the controller's state codes.
`timescale 1ns/1ps
package tank_pkg;

    localparam logic [1:0] REGION_EMPTY   = 2'b00;
    localparam logic [1:0] REGION_HALF    = 2'b01;
    localparam logic [1:0] REGION_FULL    = 2'b11;
    localparam logic [1:0] REGION_INVALID = 2'b10;

    // Upper and lower level sensors, packed in region order {s, i}.
    typedef struct packed {
        logic s_sens;
        logic i_sens;
    } sensor_pair_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter that stops at 16'hFFFF. It has a synchronous clear and
// an increment enable.
`timescale 1ns/1ps
module sat_counter16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_reg;

    // Count up on inc and hold once the counter reaches full scale.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/tank_plant_model.sv
// Closed-loop water tank plant model. Pump commands fill the tank and the
// drain empties it once per plant tick. The level drives the low and high
// sensors back to the controller.
// Optional build macro SENSOR_FAULT_EN adds the stuck-sensor fault inputs.
`timescale 1ns/1ps
module tank_plant_model
    import tank_pkg::*;
#(
    parameter int LEVEL_W    = 8,
    parameter int CAPACITY   = 200,
    parameter int LOW_MARK   = 60,
    parameter int HIGH_MARK  = 160,
    parameter int FILL_RATE  = 2,
    parameter int TICK_DIV   = 4,
    parameter int INIT_LEVEL = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               b1,
    input  logic               b2,
    input  logic               drain_en,
    input  logic [3:0]         drain_rate,
    input  logic               clear_flags,
`ifdef SENSOR_FAULT_EN
    input  logic               fault_s_stuck,
    input  logic               fault_i_stuck,
`endif
    output logic               i_sens,
    output logic               s_sens,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         region,
    output logic               overflow,
    output logic               underflow,
    output logic [15:0]        run1_cnt,
    output logic [15:0]        run2_cnt
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    // Three extra bits give headroom for the fill and a sign for drains.
    localparam int SUM_W = LEVEL_W + 3;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);
    localparam logic INIT_I = (INIT_LEVEL >= LOW_MARK);
    localparam logic INIT_S = (INIT_LEVEL >= HIGH_MARK);

    logic [PRESC_W-1:0]      presc_reg;
    logic                    tick;
    logic [LEVEL_W-1:0]      level_reg;
    logic [LEVEL_W-1:0]      level_next;
    logic [SUM_W-1:0]        fill_amt;
    logic [SUM_W-1:0]        drain_amt;
    logic signed [SUM_W-1:0] nxt;
    logic                    clip_high;
    logic                    clip_low;
    logic                    overflow_reg;
    logic                    underflow_reg;
    sensor_pair_t            sens_reg;
    sensor_pair_t            sens_next;
    logic [1:0]              region_reg;
    logic [1:0]              region_next;

    assign tick = (presc_reg == PRESC_LAST);

    // Prescaler sets the plant tick rate. Reset restarts the count, so a pending tick is aborted.
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Net the fill against the drain in signed arithmetic, then clip the result to 0..CAPACITY.
    always_comb begin
        fill_amt   = SUM_W'(FILL_RATE) * (SUM_W'(b1) + SUM_W'(b2));
        drain_amt  = drain_en ? SUM_W'(drain_rate) : '0;
        nxt        = $signed(SUM_W'(level_reg) + fill_amt - drain_amt);
        clip_low   = nxt[SUM_W-1];
        clip_high  = !clip_low && (nxt > CAP_S);
        level_next = nxt[LEVEL_W-1:0];
        if (clip_high) begin
            level_next = LEVEL_W'(CAPACITY);
        end else if (clip_low) begin
            level_next = '0;
        end
    end

    // Update the level only on a tick. A flag set by a tick overrides a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_reg     <= LEVEL_W'(INIT_LEVEL);
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (tick) begin
                level_reg <= level_next;
            end
            overflow_reg  <= (overflow_reg  && !clear_flags) || (tick && clip_high);
            underflow_reg <= (underflow_reg && !clear_flags) || (tick && clip_low);
        end
    end

    // Derive the sensors from the committed level, so they follow it by one clock. Faults act here.
    always_comb begin
        sens_next.i_sens = (level_reg >= LEVEL_W'(LOW_MARK));
        sens_next.s_sens = (level_reg >= LEVEL_W'(HIGH_MARK));
`ifdef SENSOR_FAULT_EN
        if (fault_s_stuck) begin
            sens_next.s_sens = 1'b1;
        end
        if (fault_i_stuck) begin
            sens_next.i_sens = 1'b0;
        end
`endif
    end

    // Region state follows the sensor pair directly. Jumps across regions are allowed.
    always_comb begin
        case ({sens_next.s_sens, sens_next.i_sens})
            2'b00:   region_next = REGION_EMPTY;
            2'b01:   region_next = REGION_HALF;
            2'b11:   region_next = REGION_FULL;
            default: region_next = REGION_INVALID;
        endcase
    end

    // Sensor and region registers. On reset they reflect INIT_LEVEL.
    always_ff @(posedge clk) begin
        if (reset) begin
            sens_reg.i_sens <= INIT_I;
            sens_reg.s_sens <= INIT_S;
            region_reg      <= {INIT_S, INIT_I};
        end else begin
            sens_reg   <= sens_next;
            region_reg <= region_next;
        end
    end

    sat_counter16 u_run1 (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (tick && b1),
        .count (run1_cnt)
    );

    sat_counter16 u_run2 (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (tick && b2),
        .count (run2_cnt)
    );

    assign level     = level_reg;
    assign i_sens    = sens_reg.i_sens;
    assign s_sens    = sens_reg.s_sens;
    assign region    = region_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule
